fp8_dot_seq: RTL and testbench
==============================

# fp8_dot_seq

Dot-product sequencer for the matrix-multiplication datapath. It accepts a stream of 8-bit float operand pairs, multiplies each pair internally, and drives the existing combinational fp8 adder with the running sum and the new product. It registers the adder's result as the accumulator and emits the finished dot product after `N_TERMS` pairs through a valid/ready output. It sits directly upstream of the adder, feeding its two operands and consuming its sum.

## Interface
- `N_TERMS`, default 4: operand pairs per dot product. Legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous abort of the current dot product.
- `in_valid`  in  1  operand pair `a`/`b` is valid.
- `in_ready`  out  1  block accepts a pair this cycle.
- `a`, `b`  in  8 each  fp8 operands.
- `add_x`  out  8  adder operand: accumulator.
- `add_y`  out  8  adder operand: product of `a` and `b`.
- `add_z`  in  8  adder sum; combinational from `add_x`/`add_y`.
- `out_valid`  out  1  dot product available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  8  dot product.

## Operation
- **fp8 format:** `{sign, exp[2:0], frac[3:0]}`, hidden leading 1, exponent bias 3.
  - Any value with `[6:0]==0` is zero.
  - The canonical zero produced by this block is `0x00`.
- **Multiply (combinational):**
  - If either operand is zero, the result is `0x00`.
  - Otherwise: sign = `a[7]^b[7]`; mantissa product = `{1,fa}*{1,fb}` (10 bits); exponent = `ea+eb-3`, computed signed, at least 5 bits wide.
  - If mantissa bit 9 is set: frac = `m[8:5]` and exponent +1. Otherwise frac = `m[7:4]`. Truncate, no rounding.
  - Exponent > 7: saturate to `{sign,7'h7F}`.
  - Exponent < 0: flush to `0x00`.
- **Adder drive:** `add_x` = accumulator and `add_y` = product at all times, regardless of `in_valid`.
- **FSM states:**
  - ACC: `in_ready=1`. On `in_valid&&in_ready`: accumulator ← `add_z`, term counter +1.
    - If that accepted pair is number `N_TERMS` (count reaches `N_TERMS-1` before the increment), go to DONE.
  - DONE: `in_ready=0`, `out_valid=1`, `out_data` = accumulator (held stable).
    - On `out_ready`: accumulator ← `0x00`, counter ← 0, go to ACC.
- **Counter:** 8 bits, cleared on every return to ACC; no wrap within a dot product.
- **`clear`:** overrides everything except reset.
  - Accumulator ← `0x00`, counter ← 0, state ← ACC.
  - Any accept or output handshake in the same cycle is discarded; a pending DONE result is dropped.
- **Reset** (async assert, sync deassert assumed upstream):
  - accumulator `0x00`, counter 0, state ACC.
  - Outputs: `out_valid=0`, `out_data=0x00`, `in_ready=1`, `add_x=0x00`.
  - Mid-dot-product reset discards partial sums.

## Timing
- Accept-to-accumulate latency: 1 edge. The sum is visible on `add_x` the cycle after acceptance.
- Last accept at edge k: `out_valid` rises after edge k. Earliest handshake is at edge k+1, and `in_ready` is high again after it.
- Peak throughput: `N_TERMS` pairs per `N_TERMS+1` cycles. No combinational path from `out_ready` to `in_ready`.
- `out_valid` never drops without a handshake, `clear` or reset.
- `in_ready` depends only on state, never on `in_valid`.
- One combinational path: `a`/`b` → multiply → `add_y` → external adder → `add_z` → accumulator D input. The clock must cover multiply plus adder.

## Structure
- Shared package `fp8_pkg`:
  - field widths and positions, `FP8_BIAS=3`, `FP8_ZERO=8'h00`, `FP8_MAX_MAG=7'h7F`;
  - typedef `fp8_t`;
  - FSM state enum `{ACC, DONE}`.
- One sub-module: `fp8_mul`, purely combinational, covering the multiply rules above.
- The sequencer contains only the FSM, counter, accumulator and handshake logic.
- The adder is instantiated at the parent level, not inside this block.

## Test plan
The bench connects an ideal truncating fp8 adder model to `add_x`/`add_y`/`add_z`.

- **Multiply values:** `0x38*0x38` → `add_y=0x42`; `0xB0*0x30` → `0xB0`; `0x70*0x70` → `0x7F`; `0x10*0x10` → `0x00`; `0x00*0x55` → `0x00`.
- **Basic dot product:** N=4, four pairs `(0x30,0x30)` back-to-back → accumulator steps `0x30`, `0x40`, `0x48`, `0x50`; `out_valid` the cycle after the 4th accept, `out_data=0x50`, `in_ready=0` meanwhile.
- **Backpressure:** hold `out_ready=0` for 5 cycles → `out_data` and `out_valid` stable, no pairs accepted. Then `out_ready=1` → next cycle `in_ready=1` with accumulator `0x00`.
- **Clear:** assert `clear` after 2 accepts, with `in_valid` high in the same cycle → accumulator `0x00`, counter 0; the following 4 pairs produce a correct, fresh result.
- **Reset mid-operation:** pulse `rst_n` low between clock edges with 3 terms accumulated → outputs take reset values immediately; the next run yields only new terms.
- **Edge cases:** N=1 → every accepted pair goes straight to DONE with `out_data` = its product. Gapped `in_valid` (idle cycles between pairs) → accumulator is not updated on idle cycles.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared fp8 definitions: field layout, special encodings and sequencer states.
package fp8_pkg;

  localparam int FP8_W     = 8;
  localparam int FRAC_W    = 4;
  localparam int EXP_W     = 3;
  localparam int FRAC_LSB  = 0;
  localparam int EXP_LSB   = FRAC_LSB + FRAC_W;
  localparam int SIGN_POS  = EXP_LSB + EXP_W;
  localparam int FP8_BIAS  = 3;

  localparam logic [FP8_W-1:0] FP8_ZERO    = 8'h00;
  localparam logic [FP8_W-2:0] FP8_MAX_MAG = 7'h7F;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp8_t;

  typedef enum logic {ACC, DONE} seq_state_t;

  // Any encoding with zero magnitude bits is zero, whatever the sign.
  function automatic logic fp8_is_zero(input fp8_t v);
    return (v.exp == '0) && (v.frac == '0);
  endfunction

endpackage

// File: rtl/fp8_mul.sv
// Combinational fp8 multiplier: truncating, saturates on overflow, flushes on underflow.
module fp8_mul
  import fp8_pkg::*;
(
  input  fp8_t a,
  input  fp8_t b,
  output fp8_t p
);

  logic [9:0]        m;
  logic signed [5:0] e;
  logic [3:0]        f;
  logic              unused_low_bits;

  // Low product bits fall below the 4-bit fraction and are truncated.
  assign unused_low_bits = ^m[3:0];

  // Mantissa product, normalisation and range handling.
  always_comb begin
    m = 10'({1'b1, a.frac}) * 10'({1'b1, b.frac});
    e = $signed({3'b000, a.exp}) + $signed({3'b000, b.exp}) - $signed(6'(FP8_BIAS));
    f = m[7:4];
    if (m[9]) begin
      f = m[8:5];
      e = e + 6'sd1;
    end
    p = FP8_ZERO;
    if (fp8_is_zero(a) || fp8_is_zero(b)) begin
      p = FP8_ZERO;
    end else if (e > 6'sd7) begin
      p = {a.sign ^ b.sign, FP8_MAX_MAG};
    end else if (e < 6'sd0) begin
      p = FP8_ZERO;
    end else begin
      p = {a.sign ^ b.sign, e[2:0], f};
    end
  end

endmodule

// File: rtl/fp8_dot_seq.sv
// Dot-product sequencer: feeds an external fp8 adder with accumulator and
// product, registers its sum, and hands out the result after N_TERMS pairs.
//
// state | meaning
// ACC   | accepting operand pairs, accumulating through the external adder
// DONE  | result held on out_data until the consumer takes it
module fp8_dot_seq
  import fp8_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] add_x,
  output logic [7:0] add_y,
  input  logic [7:0] add_z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  localparam logic [7:0] LAST = 8'(N_TERMS - 1);

  seq_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  fp8_t       acc, acc_nxt;
  fp8_t       prod;

  fp8_mul u_mul (
    .a (a),
    .b (b),
    .p (prod)
  );

  assign add_x    = acc;
  assign add_y    = prod;
  assign out_data = acc;

  // State, counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      cnt   <= '0;
      acc   <= FP8_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  // Next-state and handshake outputs; clear overrides any handshake.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt = add_z;
          cnt_nxt = cnt + 8'd1;
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_nxt   = FP8_ZERO;
          cnt_nxt   = '0;
          state_nxt = ACC;
        end
      end
    endcase
    if (clear) begin
      acc_nxt   = FP8_ZERO;
      cnt_nxt   = '0;
      state_nxt = ACC;
    end
  end

endmodule

// File: tb/tb_fp8_dot_seq.sv
// Bench for fp8_dot_seq: ideal truncating adder model on the adder port,
// scoreboard of expected dot products compared when out_valid is seen.
module tb_fp8_dot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, in_valid, out_ready;
  logic [7:0] a, b;
  logic       in_ready, out_valid;
  logic [7:0] add_x, add_y, add_z, out_data;

  logic       clear1, in_valid1, out_ready1;
  logic       in_ready1, out_valid1;
  logic [7:0] add_x1, add_y1, add_z1, out_data1;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_acc;
  int         m_cnt;
  logic [7:0] q4[$];
  logic [7:0] q1[$];
  logic [7:0] held;
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  // Magnitude in units of 2^-7.
  function automatic int fp8_mag(input logic [7:0] v);
    if (v[6:0] == 7'd0) return 0;
    return (16 + int'(v[3:0])) << v[6:4];
  endfunction

  function automatic logic [7:0] fp8_pack(input logic s, input int mag);
    int t;
    logic [2:0] e;
    if (mag >= 4096) return {s, 7'h7F};
    if (mag < 16) return 8'h00;
    t = mag;
    e = 3'd0;
    while (t > 31) begin
      t = t >>> 1;
      e = e + 3'd1;
    end
    return {s, e, t[3:0]};
  endfunction

  function automatic logic [7:0] ref_add(input logic [7:0] x, input logic [7:0] y);
    int sx, sy, sum;
    sx = x[7] ? -fp8_mag(x) : fp8_mag(x);
    sy = y[7] ? -fp8_mag(y) : fp8_mag(y);
    sum = sx + sy;
    if (sum < 0) return fp8_pack(1'b1, -sum);
    return fp8_pack(1'b0, sum);
  endfunction

  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    if (x[6:0] == 7'd0 || y[6:0] == 7'd0) return 8'h00;
    p = (fp8_mag(x) * fp8_mag(y)) >>> 7;
    return fp8_pack(x[7] ^ y[7], p);
  endfunction

  assign add_z  = ref_add(add_x, add_y);
  assign add_z1 = ref_add(add_x1, add_y1);

  fp8_dot_seq #(.N_TERMS(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .add_x(add_x), .add_y(add_y), .add_z(add_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  fp8_dot_seq #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .add_x(add_x1), .add_y(add_y1), .add_z(add_z1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  // Drive one pair for one edge (called at posedge+1) and update the model.
  task automatic accept(input logic [7:0] pa, input logic [7:0] pb);
    a = pa;
    b = pb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_acc = ref_add(m_acc, ref_mul(pa, pb));
    m_cnt++;
    if (m_cnt == 4) begin
      q4.push_back(m_acc);
      m_acc = 8'h00;
      m_cnt = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    a = 8'h00; b = 8'h00;
    m_acc = 8'h00; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (add_x !== 8'h00) begin errors++; $display("FAIL reset_add_x: got %h want 00", add_x); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [7:0] ta[5] = '{8'h38, 8'hB0, 8'h70, 8'h10, 8'h00};
    logic [7:0] tb[5] = '{8'h38, 8'h30, 8'h70, 8'h10, 8'h55};
    logic [7:0] te[5] = '{8'h42, 8'hB0, 8'h7F, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      a = ta[i]; b = tb[i];
      #1;
      checks++;
      if (add_y !== te[i]) begin
        errors++;
        $display("FAIL mul_%0d (%h*%h): got %h want %h", i, ta[i], tb[i], add_y, te[i]);
      end
    end
    checks++; if (add_x !== 8'h00) begin errors++; $display("FAIL mul_idle_add_x: got %h want 00", add_x); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] steps[4] = '{8'h30, 8'h40, 8'h48, 8'h50};
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_%0d: got %b want 1", i, in_ready); end
      accept(8'h30, 8'h30);
      checks++; if (add_x !== steps[i]) begin errors++; $display("FAIL basic_acc_%0d: got %h want %h", i, add_x, steps[i]); end
      if (i == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready); end
    held = q4.pop_front();
    checks++; if (out_data !== held) begin errors++; $display("FAIL basic_out_data: got %h want %h", out_data, held); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    a = 8'h38; b = 8'h38; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d: got %b want 1", i, out_valid); end
      checks++; if (out_data !== held) begin errors++; $display("FAIL bp_out_data_%0d: got %h want %h", i, out_data, held); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    checks++; if (add_x !== 8'h00) begin errors++; $display("FAIL bp_release_acc: got %h want 00", add_x); end
  endtask

  task automatic run_four(input string tag, input logic [7:0] pa[4], input logic [7:0] pb[4]);
    for (int i = 0; i < 4; i++) accept(pa[i], pb[i]);
  endtask

  task automatic test_clear();
    logic [7:0] pa[4] = '{8'h38, 8'h30, 8'hB0, 8'h44};
    logic [7:0] pb[4] = '{8'h38, 8'h40, 8'h30, 8'h32};
    accept(8'h38, 8'h38);
    accept(8'h30, 8'h40);
    checks++; if (add_x !== m_acc) begin errors++; $display("FAIL clear_pre_acc: got %h want %h", add_x, m_acc); end
    a = 8'hB0; b = 8'h30; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    m_acc = 8'h00; m_cnt = 0;
    checks++; if (add_x !== 8'h00) begin errors++; $display("FAIL clear_acc: got %h want 00", add_x); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      accept(pa[i], pb[i]);
      if (i == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_count_restart: got %b want 0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_out_valid: got %b want 1", out_valid); end
    exp_v = q4.pop_front();
    checks++; if (out_data !== exp_v) begin errors++; $display("FAIL clear_result: got %h want %h", out_data, exp_v); end
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_drop_valid: got %b want 0", out_valid); end
    checks++; if (add_x !== 8'h00) begin errors++; $display("FAIL clear_drop_acc: got %h want 00", add_x); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pa[4] = '{8'h40, 8'h3C, 8'hB8, 8'h30};
    logic [7:0] pb[4] = '{8'h30, 8'h34, 8'h30, 8'h40};
    accept(8'h38, 8'h38);
    accept(8'h30, 8'h40);
    accept(8'h44, 8'h32);
    checks++; if (add_x !== m_acc) begin errors++; $display("FAIL rmid_pre_acc: got %h want %h", add_x, m_acc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (add_x !== 8'h00) begin errors++; $display("FAIL rmid_add_x: got %h want 00", add_x); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    #1 rst_n = 1'b1;
    m_acc = 8'h00; m_cnt = 0;
    @(posedge clk); #1;
    run_four("rmid", pa, pb);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_out_valid_done: got %b want 1", out_valid); end
    exp_v = q4.pop_front();
    checks++; if (out_data !== exp_v) begin errors++; $display("FAIL rmid_result: got %h want %h", out_data, exp_v); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    logic [7:0] pa[4] = '{8'h3C, 8'h28, 8'hC0, 8'h36};
    logic [7:0] pb[4] = '{8'h34, 8'h48, 8'h30, 8'h3A};
    for (int i = 0; i < 4; i++) begin
      accept(pa[i], pb[i]);
      if (i < 3) begin
        for (int j = 0; j < 2; j++) begin
          a = 8'h50 + 8'(j); b = 8'h38; in_valid = 1'b0;
          @(posedge clk); #1;
          checks++;
          if (add_x !== m_acc) begin
            errors++;
            $display("FAIL gap_idle_%0d_%0d: got %h want %h", i, j, add_x, m_acc);
          end
        end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid: got %b want 1", out_valid); end
    exp_v = q4.pop_front();
    checks++; if (out_data !== exp_v) begin errors++; $display("FAIL gap_result: got %h want %h", out_data, exp_v); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gap_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_n1();
    logic [7:0] pa[3] = '{8'h38, 8'hB0, 8'h70};
    logic [7:0] pb[3] = '{8'h38, 8'h30, 8'h70};
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL n1_in_ready_%0d: got %b want 1", i, in_ready1); end
      a = pa[i]; b = pb[i]; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      q1.push_back(ref_mul(pa[i], pb[i]));
      checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL n1_out_valid_%0d: got %b want 1", i, out_valid1); end
      exp_v = q1.pop_front();
      checks++; if (out_data1 !== exp_v) begin errors++; $display("FAIL n1_result_%0d: got %h want %h", i, out_data1, exp_v); end
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      checks++; if (add_x1 !== 8'h00) begin errors++; $display("FAIL n1_acc_after_%0d: got %h want 00", i, add_x1); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_basic();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_gapped();
    test_n1();
    checks++;
    if (q4.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", q4.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
